// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: default byte width,
// error-flag bit positions and the stored entry layout.
package uart_rx_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    // Bit positions inside the 2-bit error field of an entry
    localparam int ERR_PAR = 1;
    localparam int ERR_STP = 0;

    // One stored frame: error flags above the data byte
    typedef struct packed {
        logic [1:0]                err;
        logic [DEF_DATA_WIDTH-1:0] data;
    } uart_entry_t;

    // Place the receiver's error strobes into their error-field positions
    function automatic logic [1:0] pack_err(input logic par, input logic stp);
        logic [1:0] e;
        e          = '0;
        e[ERR_PAR] = par;
        e[ERR_STP] = stp;
        return e;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read.
// Contents are never reset; validity is tracked by the pointer logic.
module uart_rx_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the entry at the tail slot when a push is accepted
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver. Captures one entry per
// data_valid rising edge, presents the head entry first-word-fall-through,
// and raises a sticky overrun flag when a frame arrives while full.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int DROP_ERR   = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    P_DATA,
    input  logic                     PAR_ERR,
    input  logic                     STP_ERR,
    input  logic                     data_valid,
    input  logic                     rd_ready,
    input  logic                     clr_ovr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [1:0]               rd_err,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam bit DROP_EN = (DROP_ERR != 0);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          dv_q;
    logic          overrun_q;

    logic          push_req;
    logic          dropped;
    logic          pop;
    logic          push;
    logic          ovr_evt;
    logic [EW-1:0] wdata;
    logic [EW-1:0] mem_rdata;

    // Status flags derive from the registered count only
    assign rd_valid = (count_q != '0);
    assign full     = (count_q == DEPTH_CNT);
    assign count    = count_q;
    assign overrun  = overrun_q;

    // Head entry is shown only while non-empty so an empty FIFO reads as zero
    assign rd_data  = rd_valid ? mem_rdata[DATA_WIDTH-1:0] : '0;
    assign rd_err   = rd_valid ? mem_rdata[EW-1:DATA_WIDTH] : '0;

    assign wdata    = {pack_err(PAR_ERR, STP_ERR), P_DATA};

    // Push/pop/overrun decisions for the current cycle
    always_comb begin
        push_req = data_valid & ~dv_q;
        dropped  = DROP_EN & (PAR_ERR | STP_ERR);
        pop      = rd_valid & rd_ready;
        push     = push_req & ~dropped & (~full | pop);
        ovr_evt  = push_req & ~dropped & full & ~pop;
    end

    // Strobe history so a long data_valid pulse yields a single push
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dv_q <= 1'b0;
        end else begin
            dv_q <= data_valid;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH naturally
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overrun; a new overrun takes priority over a clear request
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overrun_q <= 1'b0;
        end else if (ovr_evt) begin
            overrun_q <= 1'b1;
        end else if (clr_ovr) begin
            overrun_q <= 1'b0;
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (CLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances (errored frames kept / dropped)
// share one stimulus stream and are compared against a queue-based model.
module tb_uart_rx_fifo;
    import uart_rx_pkg::*;

    localparam int DEPTH = 8;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       data_valid;
    logic       rd_ready;
    logic       clr_ovr;

    logic [7:0] rd_data0, rd_data1;
    logic [1:0] rd_err0, rd_err1;
    logic       rd_valid0, rd_valid1;
    logic       full0, full1;
    logic [3:0] count0, count1;
    logic       overrun0, overrun1;

    int vectors;
    int miscompares;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_ERR(0)) dut_keep (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
        .data_valid(data_valid), .rd_ready(rd_ready), .clr_ovr(clr_ovr),
        .rd_data(rd_data0), .rd_err(rd_err0), .rd_valid(rd_valid0), .full(full0),
        .count(count0), .overrun(overrun0)
    );

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_ERR(1)) dut_drop (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
        .data_valid(data_valid), .rd_ready(rd_ready), .clr_ovr(clr_ovr),
        .rd_data(rd_data1), .rd_err(rd_err1), .rd_valid(rd_valid1), .full(full1),
        .count(count1), .overrun(overrun1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: one queue of frames per instance plus sticky overrun
    uart_entry_t q0[$];
    uart_entry_t q1[$];
    bit          ovr0, ovr1;
    bit          m_dvq;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        ovr0  = 1'b0;
        ovr1  = 1'b0;
        m_dvq = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        bit          rise, err, pop0, pop1, full_b0, full_b1, ev0, ev1;
        uart_entry_t e;
        rise    = data_valid && !m_dvq;
        err     = PAR_ERR || STP_ERR;
        e.data  = P_DATA;
        e.err   = {PAR_ERR, STP_ERR};
        full_b0 = (q0.size() == DEPTH);
        full_b1 = (q1.size() == DEPTH);
        pop0    = (q0.size() > 0) && rd_ready;
        pop1    = (q1.size() > 0) && rd_ready;
        ev0     = 1'b0;
        ev1     = 1'b0;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        if (rise) begin
            if (!full_b0 || pop0) q0.push_back(e);
            else ev0 = 1'b1;
            if (!err) begin
                if (!full_b1 || pop1) q1.push_back(e);
                else ev1 = 1'b1;
            end
        end
        ovr0  = ev0 ? 1'b1 : (clr_ovr ? 1'b0 : ovr0);
        ovr1  = ev1 ? 1'b1 : (clr_ovr ? 1'b0 : ovr1);
        m_dvq = data_valid;
    endtask

    task automatic check_model(input string tag);
        int h0, h1, e0, e1;
        h0 = (q0.size() > 0) ? int'(q0[0].data) : 0;
        e0 = (q0.size() > 0) ? int'(q0[0].err)  : 0;
        h1 = (q1.size() > 0) ? int'(q1[0].data) : 0;
        e1 = (q1.size() > 0) ? int'(q1[0].err)  : 0;
        check({tag, ".count0"},   int'(count0),   q0.size());
        check({tag, ".valid0"},   int'(rd_valid0), int'(q0.size() != 0));
        check({tag, ".full0"},    int'(full0),    int'(q0.size() == DEPTH));
        check({tag, ".data0"},    int'(rd_data0), h0);
        check({tag, ".err0"},     int'(rd_err0),  e0);
        check({tag, ".overrun0"}, int'(overrun0), int'(ovr0));
        check({tag, ".count1"},   int'(count1),   q1.size());
        check({tag, ".data1"},    int'(rd_data1), h1);
        check({tag, ".err1"},     int'(rd_err1),  e1);
        check({tag, ".overrun1"}, int'(overrun1), int'(ovr1));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic tick(input string tag);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_model(tag);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int len, input string tag);
        P_DATA     = d;
        PAR_ERR    = par;
        STP_ERR    = stp;
        data_valid = 1'b1;
        repeat (len) tick(tag);
        data_valid = 1'b0;
        PAR_ERR    = 1'b0;
        STP_ERR    = 1'b0;
        tick(tag);
    endtask

    typedef struct {
        logic       dv;
        logic [7:0] d;
        logic       par;
        logic       stp;
        logic       rdy;
        int         c0;
        logic [7:0] h0;
        logic [1:0] e0;
        int         c1;
        logic [7:0] h1;
        logic [1:0] e1;
    } vec_t;

    vec_t tbl[9];

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST         = 1'b0;
        P_DATA      = '0;
        PAR_ERR     = 1'b0;
        STP_ERR     = 1'b0;
        data_valid  = 1'b0;
        rd_ready    = 1'b0;
        clr_ovr     = 1'b0;
        model_reset();

        // Reset state is visible without any clock edge
        #1;
        check("reset.count",   int'(count0),   0);
        check("reset.valid",   int'(rd_valid0), 0);
        check("reset.full",    int'(full0),    0);
        check("reset.overrun", int'(overrun0), 0);
        check("reset.data",    int'(rd_data0), 0);
        check("reset.err",     int'(rd_err0),  0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        tick("idle");

        // Single long strobe, then parity/stop tagging and dropping
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 2'b00, 1, 8'hA5, 2'b00};
        tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 2'b00, 1, 8'hA5, 2'b00};
        tbl[2] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 2'b00, 1, 8'hA5, 2'b00};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 2'b00, 1, 8'hA5, 2'b00};
        tbl[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 2, 8'hA5, 2'b00, 1, 8'hA5, 2'b00};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 8'h3C, 2'b10, 0, 8'h00, 2'b00};
        tbl[6] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 2, 8'h3C, 2'b10, 0, 8'h00, 2'b00};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 8'h3C, 2'b01, 0, 8'h00, 2'b00};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00};
        for (int i = 0; i < 9; i++) begin
            data_valid = tbl[i].dv;
            P_DATA     = tbl[i].d;
            PAR_ERR    = tbl[i].par;
            STP_ERR    = tbl[i].stp;
            rd_ready   = tbl[i].rdy;
            tick("tbl");
            check($sformatf("tbl%0d.count0", i), int'(count0),    tbl[i].c0);
            check($sformatf("tbl%0d.valid0", i), int'(rd_valid0), int'(tbl[i].c0 != 0));
            check($sformatf("tbl%0d.data0", i),  int'(rd_data0),  int'(tbl[i].h0));
            check($sformatf("tbl%0d.err0", i),   int'(rd_err0),   int'(tbl[i].e0));
            check($sformatf("tbl%0d.count1", i), int'(count1),    tbl[i].c1);
            check($sformatf("tbl%0d.data1", i),  int'(rd_data1),  int'(tbl[i].h1));
            check($sformatf("tbl%0d.err1", i),   int'(rd_err1),   int'(tbl[i].e1));
            check($sformatf("tbl%0d.ovr1", i),   int'(overrun1),  0);
        end
        data_valid = 1'b0;
        PAR_ERR    = 1'b0;
        STP_ERR    = 1'b0;
        rd_ready   = 1'b0;

        // Fill to full, one extra frame overruns and is lost
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 1, "fill");
            if (i == 7) begin
                check("fill8.full",    int'(full0),    1);
                check("fill8.overrun", int'(overrun0), 0);
            end
        end
        check("fill9.count",   int'(count0),   8);
        check("fill9.full",    int'(full0),    1);
        check("fill9.overrun", int'(overrun0), 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d.data", i), int'(rd_data0), i);
            tick("drain");
        end
        rd_ready = 1'b0;
        check("drain.valid", int'(rd_valid0), 0);

        // Clear, refill, then clear and overrun in the same cycle
        clr_ovr = 1'b1;
        tick("clr");
        clr_ovr = 1'b0;
        check("clr.overrun", int'(overrun0), 0);
        for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1, "refill");
        P_DATA     = 8'hDD;
        data_valid = 1'b1;
        clr_ovr    = 1'b1;
        tick("race");
        check("race.overrun", int'(overrun0), 1);
        data_valid = 1'b0;
        clr_ovr    = 1'b0;
        tick("race");
        clr_ovr = 1'b1;
        tick("race");
        clr_ovr = 1'b0;
        check("race.cleared", int'(overrun0), 0);

        // Push and pop together while full
        P_DATA     = 8'hEE;
        data_valid = 1'b1;
        rd_ready   = 1'b1;
        tick("pp");
        check("pp.count", int'(count0),   8);
        check("pp.full",  int'(full0),    1);
        check("pp.head",  int'(rd_data0), 8'h11);
        data_valid = 1'b0;
        rd_ready   = 1'b0;
        tick("pp");
        rd_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("pp_drain%0d", i), int'(rd_data0), 8'h10 + i);
            tick("pp_drain");
        end
        check("pp_drain.tail", int'(rd_data0), 8'hEE);
        tick("pp_drain");
        rd_ready = 1'b0;

        // Random traffic: many frames, pointer wrap, random errors and reads
        for (int c = 0; c < 400; c++) begin
            data_valid = ($urandom_range(0, 1) == 1);
            P_DATA     = 8'($urandom);
            PAR_ERR    = ($urandom_range(0, 7) == 0);
            STP_ERR    = ($urandom_range(0, 7) == 0);
            rd_ready   = ($urandom_range(0, 2) != 0);
            clr_ovr    = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        data_valid = 1'b0;
        PAR_ERR    = 1'b0;
        STP_ERR    = 1'b0;
        clr_ovr    = 1'b0;
        rd_ready   = 1'b1;
        repeat (10) tick("flush");
        rd_ready = 1'b0;

        // Asynchronous reset between edges with entries stored
        for (int i = 0; i < 5; i++) send_frame(8'(8'h40 + i), 1'b0, 1'b0, 2, "pre_rst");
        check("pre_rst.count", int'(count0), 5);
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check("arst.count",   int'(count0),   0);
        check("arst.valid",   int'(rd_valid0), 0);
        check("arst.full",    int'(full0),    0);
        check("arst.overrun", int'(overrun0), 0);
        check("arst.data",    int'(rd_data0), 0);
        @(negedge CLK);
        RST = 1'b1;
        tick("post_rst");
        send_frame(8'h5A, 1'b0, 1'b0, 1, "post_rst");
        check("post_rst.data", int'(rd_data0), 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
